sram_writer: RTL

- Write-side sequencer for the external 8-bit asynchronous SRAM. The VGA scan-out engine is the read side of the same bus.
- Buffers CPU byte-write requests in a small FIFO and issues timed write cycles: address/data setup, WE# pulse, hold.
- Yields the bus to the VGA reader between write cycles. Sits between the CPU I/O decode and the SRAM pins/address mux in top.

---
 rtl/sram_writer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sram_writer.sv
// sram_writer: write-side sequencer for the external asynchronous SRAM.
// CPU byte writes are queued in a small FIFO. Each queued entry becomes one
// timed write cycle: address/data setup, WE# low pulse, then hold. Between
// write cycles the bus is released so the VGA reader can use it.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   req_valid    write request present
//   req_ready    FIFO can accept a request (registered count, not full)
//   req_addr     target address
//   req_data     byte to write
//   rd_req       VGA reader wants the bus; wins whenever this block is idle
//   bus_own      1 = top-level address mux selects sram_addr
//   sram_addr    registered write address
//   sram_data_o  registered write data
//   sram_data_oe 1 = drive the SRAM data pins
//   sram_we_n    active-low write enable
//   pending      entries queued, not counting the write in flight
//   idle         FIFO empty and no write in progress
module sram_writer #(
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SETUP      = 2,
  parameter int unsigned PULSE      = 3,
  parameter int unsigned HOLD       = 1,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_data,
  input  logic                  rd_req,
  output logic                  bus_own,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_data_o,
  output logic                  sram_data_oe,
  output logic                  sram_we_n,
  output logic [DEPTH_LOG2:0]   pending,
  output logic                  idle
);

  localparam int unsigned         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL     = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [3:0]          SETUP_LD = 4'(SETUP - 1);
  localparam logic [3:0]          PULSE_LD = 4'(PULSE - 1);
  localparam logic [3:0]          HOLD_LD  = 4'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [3:0]            phase_cnt;
  logic [3:0]            phase_cnt_next;

  logic [ADDR_W-1:0]     fifo_addr [DEPTH];
  logic [DATA_W-1:0]     fifo_data [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;

  logic                  push;
  logic                  pop;
  logic                  own;
  logic                  own_next;
  logic                  we_n_next;

  // Ready depends only on the registered count; a same-cycle pop never
  // opens a slot for the request presented in that cycle.
  assign req_ready = (count != FULL);
  assign push      = req_valid & req_ready;
  assign pop       = (state == ST_IDLE) & (count != '0) & ~rd_req;

  assign pending      = count;
  assign idle         = (count == '0) & (state == ST_IDLE);
  assign bus_own      = own;
  assign sram_data_oe = own;

  // FIFO storage (no reset needed; validity is tracked by count)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= req_addr;
      fifo_data[wr_ptr] <= req_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
    end else begin
      state     <= state_next;
      phase_cnt <= phase_cnt_next;
    end
  end

  // FSM: next state and phase counter
  always_comb begin
    state_next     = state;
    phase_cnt_next = phase_cnt;
    case (state)
      ST_IDLE: begin
        if (pop) begin
          state_next     = ST_SETUP;
          phase_cnt_next = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (phase_cnt == '0) begin
          state_next     = ST_PULSE;
          phase_cnt_next = PULSE_LD;
        end else begin
          phase_cnt_next = phase_cnt - 4'd1;
        end
      end
      ST_PULSE: begin
        if (phase_cnt == '0) begin
          state_next     = ST_HOLD;
          phase_cnt_next = HOLD_LD;
        end else begin
          phase_cnt_next = phase_cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (phase_cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          phase_cnt_next = phase_cnt - 4'd1;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        phase_cnt_next = '0;
      end
    endcase
  end

  // FSM: outputs. Pin controls are decoded from the next state and then
  // registered, so each pin changes on the same edge as the state it tracks.
  always_comb begin
    own_next  = (state_next != ST_IDLE);
    we_n_next = (state_next != ST_PULSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      own         <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_addr   <= '0;
      sram_data_o <= '0;
    end else begin
      own       <= own_next;
      sram_we_n <= we_n_next;
      if (pop) begin
        sram_addr   <= fifo_addr[rd_ptr];
        sram_data_o <= fifo_data[rd_ptr];
      end
    end
  end

endmodule
